// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Front-end fetch stage. Owns the program counter, issues word fetches to
// instruction memory, collects in-order responses into a 2-slot ring and hands
// {instruction, PC} pairs to decode. A redirect flushes the ring, arranges for
// still-outstanding responses to be discarded and restarts fetch at the new PC.
//
// Handshakes: every channel uses valid/ready. A transfer happens on a rising
// clock edge where both valid and ready are high. A valid source does not
// depend on its own ready, except imem_req_valid, which looks at inst_ready
// so that a slot freed by decode can be refilled in the same cycle. The
// memory response channel has no ready: responses are always taken.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req_valid    fetch request valid            (out)
//   imem_req_ready    memory accepts the request     (in)
//   imem_req_addr     fetch address, equals the PC   (out)
//   imem_rsp_valid    in-order response valid        (in)
//   imem_rsp_data     instruction word               (in)
//   redirect_valid    single-cycle redirect strobe   (in)
//   redirect_pc       new PC, bits [1:0] ignored     (in)
//   inst_valid        head slot holds an instruction (out)
//   inst_ready        decode accepts the instruction (in)
//   inst_out          instruction word of head slot  (out)
//   inst_pc           PC of head slot                (out)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_out,
  output logic [XLEN-1:0] inst_pc
);

  // Per-slot state.
  localparam logic [1:0] SLOT_EMPTY   = 2'd0;
  localparam logic [1:0] SLOT_PENDING = 2'd1;
  localparam logic [1:0] SLOT_FULL    = 2'd2;

  logic [XLEN-1:0] pc;
  logic [1:0]      slot_st   [2];
  logic [XLEN-1:0] slot_pc   [2];
  logic [31:0]     slot_data [2];
  logic            head;
  logic            tail;
  logic [1:0]      drop_cnt;   // responses still owed to pre-redirect requests

  logic [1:0]      pend_cnt;
  logic            head_fire;
  logic            tail_free;
  logic            req_fire;
  logic            rsp_slot;
  logic [2:0]      drop_redirect;

  // The two low bits of a redirect target are always forced to zero.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    pend_cnt  = {1'b0, slot_st[0] == SLOT_PENDING} +
                {1'b0, slot_st[1] == SLOT_PENDING};

    inst_valid = (slot_st[head] == SLOT_FULL) && !redirect_valid;
    head_fire  = inst_valid && inst_ready;

    // The tail slot can be reused in the cycle the head drains it.
    tail_free  = (slot_st[tail] == SLOT_EMPTY) || ((tail == head) && head_fire);

    // Outstanding requests (live or to-be-dropped) never exceed two.
    imem_req_valid = rst_n && tail_free && !redirect_valid &&
                     (({1'b0, pend_cnt} + {1'b0, drop_cnt}) < 3'd2);
    req_fire       = imem_req_valid && imem_req_ready;

    // Responses arrive in order, so they fill the oldest PENDING slot:
    // the head if it is pending, otherwise the slot after it.
    rsp_slot = (slot_st[head] == SLOT_PENDING) ? head : ~head;

    // On redirect every PENDING slot becomes a response to drop, less the
    // one arriving right now which is discarded on the spot.
    drop_redirect = {1'b0, drop_cnt} + {1'b0, pend_cnt} - {2'b00, imem_rsp_valid};

    imem_req_addr = pc;
    inst_out      = slot_data[head];
    inst_pc       = slot_pc[head];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      head     <= 1'b0;
      tail     <= 1'b0;
      drop_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        slot_st[i]   <= SLOT_EMPTY;
        slot_pc[i]   <= '0;
        slot_data[i] <= '0;
      end
    end else if (redirect_valid) begin
      pc       <= {redirect_pc[XLEN-1:2], 2'b00};
      head     <= 1'b0;
      tail     <= 1'b0;
      drop_cnt <= drop_redirect[1:0];
      for (int i = 0; i < 2; i++) begin
        slot_st[i] <= SLOT_EMPTY;
      end
    end else begin
      if (imem_rsp_valid) begin
        if (drop_cnt != 2'd0) begin
          drop_cnt <= drop_cnt - 2'd1;
        end else begin
          slot_st[rsp_slot]   <= SLOT_FULL;
          slot_data[rsp_slot] <= imem_rsp_data;
        end
      end
      if (head_fire) begin
        slot_st[head] <= SLOT_EMPTY;
        head          <= ~head;
      end
      // Placed after the head update so a same-cycle reuse of the head
      // slot ends up PENDING rather than EMPTY.
      if (req_fire) begin
        slot_st[tail] <= SLOT_PENDING;
        slot_pc[tail] <= pc;
        tail          <= ~tail;
        pc            <= pc + XLEN'(4);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Bench for instr_fetch_unit with RESET_PC = 32'h100. A behavioural memory
// answers each accepted request after mem_lat cycles with word(addr). The main
// sequence pushes the expected {pc, word} stream into exp_q; an independent
// monitor pops and compares on every inst_valid && inst_ready transfer.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT signals
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc)
  );

  // Scoreboard state
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [63:0] exp_q[$];

  // Memory model state
  int          cyc     = 0;
  int          mem_lat = 1;
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [31:0] acc_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < acc_log.size()) return acc_log[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] p;
      p = start + 32'(4 * i);
      exp_q.push_back({p, mem_word(p)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: record accepted requests, answer mem_lat cycles later in order.
  always @(negedge clk) begin
    if (rst_n && imem_req_valid && imem_req_ready) begin
      mem_addr_q.push_back(imem_req_addr);
      mem_due_q.push_back(cyc + mem_lat);
      acc_log.push_back(imem_req_addr);
    end
  end

  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_addr_q[0]);
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  // Monitor: compare every decode transfer against the expected stream.
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_inst: got pc %h with nothing expected at %0t", inst_pc, $time);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e[63:32]);
        check("inst_out", inst_out, e[31:0]);
      end
    end
    if (rst_n && imem_rsp_valid) begin
      n_checks++;
      assert (dut.pend_cnt != 2'd0 || dut.drop_cnt != 2'd0)
      else begin
        n_fails++;
        $display("FAIL protocol: response with no pending slot and drop_cnt 0 at %0t", $time);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: sequence did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_lat        = 1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, RST_PC);

    // Streaming: one instruction per cycle from the third cycle after release
    push_seq(RST_PC, 8);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stream_valid", 32'(inst_valid), (c >= 2) ? 32'd1 : 32'd0);
    end
    tick();
    inst_ready = 1'b0;
    check("stream_drained", 32'(exp_q.size()), 32'd0);
    tick();
    check("full_valid", 32'(inst_valid), 32'd1);
    check("full_head_pc", inst_pc, 32'h0000_0120);

    // Asynchronous reset with both slots full
    @(posedge clk); #3;
    rst_n = 1'b0;
    mem_addr_q.delete();
    mem_due_q.delete();
    #1;
    check("midrst_inst_valid", 32'(inst_valid), 32'd0);
    check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    check("midrst_req_addr", imem_req_addr, RST_PC);

    // Stall from reset: exactly two requests, head held stable
    repeat (2) @(posedge clk);
    push_seq(RST_PC, 10);
    @(posedge clk); #1;
    acc_log.delete();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        check("stall_valid", 32'(inst_valid), 32'd1);
        check("stall_pc", inst_pc, RST_PC);
        check("stall_out", inst_out, mem_word(RST_PC));
      end
    end
    tick();
    check("stall_req_count", 32'(acc_log.size()), 32'd2);
    check("stall_req0", log_at(0), 32'h0000_0100);
    check("stall_req1", log_at(1), 32'h0000_0104);

    // Release with imem_req_ready toggling 1,0,1,0
    acc_log.delete();
    inst_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      imem_req_ready = (i % 2 == 0);
      tick();
    end
    imem_req_ready = 1'b0;
    repeat (4) tick();
    check("toggle_drained", 32'(exp_q.size()), 32'd0);
    check("toggle_req_count", 32'(acc_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("toggle_req_addr", log_at(i), 32'h0000_0108 + 32'(4 * i));
    end

    // Redirect with two pending slots and a same-cycle response
    mem_lat = 3;
    acc_log.delete();
    imem_req_ready = 1'b1;
    tick();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    push_seq(32'h0000_0200, 4);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_req_addr", imem_req_addr, 32'h0000_0200);
    check("redir_req_valid", 32'(imem_req_valid), 32'd1);
    check("redir_inst_valid", 32'(inst_valid), 32'd0);
    repeat (6) tick();
    imem_req_ready = 1'b0;
    repeat (8) tick();
    check("redir_drained", 32'(exp_q.size()), 32'd0);
    check("redir_req_count", 32'(acc_log.size()), 32'd6);
    check("redir_req0", log_at(0), 32'h0000_0128);
    check("redir_req1", log_at(1), 32'h0000_012C);
    check("redir_req2", log_at(2), 32'h0000_0200);
    check("redir_req3", log_at(3), 32'h0000_0204);
    check("redir_req4", log_at(4), 32'h0000_0208);
    check("redir_req5", log_at(5), 32'h0000_020C);

    // PC wrap from 32'hFFFF_FFFC to 0
    mem_lat = 1;
    acc_log.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    imem_req_ready = 1'b1;
    push_seq(32'hFFFF_FFFC, 3);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    check("wrap_addr1", imem_req_addr, 32'h0000_0000);
    tick();
    tick();
    imem_req_ready = 1'b0;
    repeat (5) tick();
    check("wrap_drained", 32'(exp_q.size()), 32'd0);
    check("wrap_req_count", 32'(acc_log.size()), 32'd3);
    check("wrap_req0", log_at(0), 32'hFFFF_FFFC);
    check("wrap_req1", log_at(1), 32'h0000_0000);
    check("wrap_req2", log_at(2), 32'h0000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
